c_pmt_fifo_n: RTL and testbench

//  Clocked, parametrised permit-gated FIFO controller for the control path; next generation of the single-stage permit FIFO.

---
 rtl/c_pmt_fifo_n_if.sv | 27 ++
 rtl/c_pmt_fifo_n.sv | 133 +++++++++++++
 tb/tb_c_pmt_fifo_n.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/c_pmt_fifo_n_if.sv
// Handshake bundle for the permit-gated token FIFO controller.
//   i_drive     upstream request pulse          (master -> slave)
//   o_free      upstream acceptance pulse       (slave  -> master)
//   pmt         per-stage permit, DEPTH bits    (master -> slave)
//   o_fire      per-stage fire pulses           (slave  -> master)
//   o_driveNext delayed downstream drive pulse  (slave  -> master)
//   i_freeNext  downstream credit return pulse  (master -> slave)
interface c_pmt_fifo_n_if #(
    parameter int unsigned DEPTH = 4
);
    logic             i_drive;
    logic             o_free;
    logic [DEPTH-1:0] pmt;
    logic [DEPTH-1:0] o_fire;
    logic             o_driveNext;
    logic             i_freeNext;

    modport master (
        output i_drive, pmt, i_freeNext,
        input  o_free, o_fire, o_driveNext
    );

    modport slave (
        input  i_drive, pmt, i_freeNext,
        output o_free, o_fire, o_driveNext
    );
endinterface

// File: rtl/c_pmt_fifo_n.sv
// Permit-gated, credit-controlled token FIFO controller for the control path.
// Data-less tokens move through DEPTH stages; a stage advances only while its
// permit is high and downstream has room, and each advance yields a fire pulse
// that latches the matching datapath stage. The last-stage fire is delayed by
// DELAY cycles to form o_driveNext, matching the datapath delay.
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous reset, active-low
//   bus          c_pmt_fifo_n_if.slave (i_drive/o_free, pmt/o_fire,
//                o_driveNext/i_freeNext)
//   o_occupancy  number of valid stages, registered   (C_PMT_FIFO_STATUS_EN)
//   o_err        sticky protocol error flag           (C_PMT_FIFO_STATUS_EN)
module c_pmt_fifo_n #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CREDITS = 1,
    parameter int unsigned DELAY   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    c_pmt_fifo_n_if.slave                bus
`ifdef C_PMT_FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
    output logic                         o_err
`endif
);

    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_n;
    logic [DEPTH-1:0] adv_c;
    logic [DEPTH-1:0] fire_q;
    logic             free_q;
    logic             pend_q;
    logic             acc_c;
    logic             room_c;
    logic [CW-1:0]    credit_q;
    logic [CW-1:0]    credit_n;
    logic             dec_c;
    logic             inc_c;
    logic [DELAY-1:0] dly_q;

    // Advance chain: evaluated from the last stage back so a stage that empties
    // this cycle makes room for its predecessor in the same cycle.
    always_comb begin
        adv_c  = '0;
        room_c = (credit_q != '0);
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            adv_c[k] = valid_q[k] & bus.pmt[k] & room_c;
            room_c   = ~valid_q[k] | adv_c[k];
        end
    end

    // Upstream accept; a pending request is served as soon as stage 0 has room.
    always_comb begin
        acc_c = (bus.i_drive | pend_q) & (~valid_q[0] | adv_c[0]);
    end

    // Next stage occupancy.
    always_comb begin
        valid_n    = valid_q & ~adv_c;
        valid_n[0] = valid_n[0] | acc_c;
        for (int k = 1; k < int'(DEPTH); k++) begin
            valid_n[k] = valid_n[k] | adv_c[k-1];
        end
    end

    // Credit counter; a return while already at the reset level is dropped.
    always_comb begin
        dec_c    = adv_c[DEPTH-1];
        inc_c    = bus.i_freeNext;
        credit_n = credit_q;
        if (dec_c && !inc_c) begin
            credit_n = credit_q - CW'(1);
        end else if (inc_c && !dec_c && (credit_q != CW'(CREDITS))) begin
            credit_n = credit_q + CW'(1);
        end
    end

    // State and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= '0;
            pend_q   <= 1'b0;
            credit_q <= CW'(CREDITS);
            fire_q   <= '0;
            free_q   <= 1'b0;
            dly_q    <= '0;
        end else begin
            valid_q  <= valid_n;
            pend_q   <= acc_c ? 1'b0 : (pend_q | bus.i_drive);
            credit_q <= credit_n;
            fire_q   <= adv_c;
            free_q   <= acc_c;
            dly_q[0] <= fire_q[DEPTH-1];
            for (int i = 1; i < int'(DELAY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign bus.o_free      = free_q;
    assign bus.o_fire      = fire_q;
    assign bus.o_driveNext = dly_q[DELAY-1];

`ifdef C_PMT_FIFO_STATUS_EN
    logic [OW-1:0] occ_n;
    logic          err_set_c;

    // Occupancy register tracks the stage count of the current cycle.
    always_comb begin
        occ_n = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_n = occ_n + OW'(valid_n[k]);
        end
        err_set_c = (bus.i_drive & pend_q)
                  | (bus.i_freeNext & ~dec_c & (credit_q == CW'(CREDITS)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_occupancy <= '0;
            o_err       <= 1'b0;
        end else begin
            o_occupancy <= occ_n;
            o_err       <= o_err | err_set_c;
        end
    end
`endif

endmodule

// File: tb/tb_c_pmt_fifo_n.sv
// Directed bench for c_pmt_fifo_n: per-cycle expected outputs are queued for
// each scenario and popped/compared every cycle.
module tb_c_pmt_fifo_n;

    typedef struct packed {
        logic       free;
        logic [3:0] fire;
        logic       drv;
    } obs_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    obs_t sb[$];
    obs_t exp_a[32];

    c_pmt_fifo_n_if #(.DEPTH(4)) b1();
    c_pmt_fifo_n_if #(.DEPTH(4)) b8();

`ifdef C_PMT_FIFO_STATUS_EN
    logic [2:0] occ1, occ8;
    logic       err1, err8;
`endif

    c_pmt_fifo_n #(.DEPTH(4), .CREDITS(1), .DELAY(2)) dut (
        .clk(clk), .rst(rst), .bus(b1)
`ifdef C_PMT_FIFO_STATUS_EN
        , .o_occupancy(occ1), .o_err(err1)
`endif
    );

    c_pmt_fifo_n #(.DEPTH(4), .CREDITS(8), .DELAY(2)) dut8 (
        .clk(clk), .rst(rst), .bus(b8)
`ifdef C_PMT_FIFO_STATUS_EN
        , .o_occupancy(occ8), .o_err(err8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        b1.i_drive    = 1'b0;
        b1.i_freeNext = 1'b0;
        b1.pmt        = 4'hF;
        b8.i_drive    = 1'b0;
        b8.i_freeNext = 1'b0;
        b8.pmt        = 4'hF;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 32; i++) exp_a[i] = '0;
    endtask

    task automatic load_exp(input int n);
        for (int i = 0; i < n; i++) sb.push_back(exp_a[i]);
    endtask

    task automatic check_obs(input obs_t got, input int c, input string tag);
        obs_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b, no expected entry queued", tag, c, got);
        end else begin
            e = sb.pop_front();
            assert (got === e) else begin
                errors++;
                $error("FAIL %s cycle %0d: observed free/fire/drv=%b expected %b", tag, c, got, e);
            end
        end
    endtask

    task automatic check_bit(input logic got, input logic e, input int c, input string tag);
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, got, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;

        // Scenario 1: single token through an empty FIFO.
        do_reset();
        clear_exp();
        exp_a[1].free = 1'b1;
        exp_a[2].fire = 4'b0001;
        exp_a[3].fire = 4'b0010;
        exp_a[4].fire = 4'b0100;
        exp_a[5].fire = 4'b1000;
        exp_a[7].drv  = 1'b1;
        load_exp(12);
        for (int c = 0; c < 12; c++) begin
            check_obs({b1.o_free, b1.o_fire, b1.o_driveNext}, c, "single");
`ifdef C_PMT_FIFO_STATUS_EN
            checks++;
            assert (occ1 === ((c >= 1 && c <= 4) ? 3'd1 : 3'd0)) else begin
                errors++;
                $error("FAIL occupancy cycle %0d: observed %0d", c, occ1);
            end
`endif
            b1.i_drive = (c == 0);
            tick();
        end

        // Scenario 2: second token stalls in the last stage until a credit returns
        // (credit pulse sampled at the edge that opens cycle 20).
        do_reset();
        clear_exp();
        exp_a[1].free  = 1'b1;
        exp_a[3].free  = 1'b1;
        exp_a[2].fire  = 4'b0001;
        exp_a[3].fire  = 4'b0010;
        exp_a[4].fire  = 4'b0101;
        exp_a[5].fire  = 4'b1010;
        exp_a[6].fire  = 4'b0100;
        exp_a[21].fire = 4'b1000;
        exp_a[7].drv   = 1'b1;
        exp_a[23].drv  = 1'b1;
        load_exp(26);
        for (int c = 0; c < 26; c++) begin
            check_obs({b1.o_free, b1.o_fire, b1.o_driveNext}, c, "credit_stall");
            b1.i_drive    = (c == 0 || c == 2);
            b1.i_freeNext = (c == 19);
            tick();
        end

        // Scenario 3: permit hold on stage 1; third request pends, fourth is
        // a protocol violation absorbed into the pending request.
        do_reset();
        clear_exp();
        exp_a[1].free  = 1'b1;
        exp_a[3].free  = 1'b1;
        exp_a[11].free = 1'b1;
        exp_a[2].fire  = 4'b0001;
        exp_a[11].fire = 4'b0011;
        exp_a[12].fire = 4'b0111;
        exp_a[13].fire = 4'b1110;
        exp_a[15].drv  = 1'b1;
        load_exp(20);
        for (int c = 0; c < 20; c++) begin
            check_obs({b1.o_free, b1.o_fire, b1.o_driveNext}, c, "permit_hold");
`ifdef C_PMT_FIFO_STATUS_EN
            if (c == 5 || c == 8 || c == 19) check_bit(err1, (c != 5), c, "err_sticky");
`endif
            b1.i_drive = (c == 0 || c == 2 || c == 4 || c == 6);
            b1.pmt     = (c >= 2 && c <= 9) ? 4'b1101 : 4'hF;
            tick();
        end
        b1.pmt = 4'hF;

        // Scenario 4: streaming with eight credits, no bubbles.
        do_reset();
        clear_exp();
        for (int t = 0; t < 8; t++) begin
            exp_a[t+1].free = 1'b1;
            for (int k = 0; k < 4; k++) exp_a[t+2+k].fire[k] = 1'b1;
            exp_a[t+7].drv = 1'b1;
        end
        load_exp(18);
        for (int c = 0; c < 18; c++) begin
            check_obs({b8.o_free, b8.o_fire, b8.o_driveNext}, c, "stream");
            b8.i_drive    = (c <= 7);
            b8.i_freeNext = (c >= 7 && c <= 14);
            tick();
        end
        b8.i_drive    = 1'b0;
        b8.i_freeNext = 1'b0;

        // Scenario 5: reset mid-flight discards tokens and restores the credit.
        do_reset();
        clear_exp();
        exp_a[1].free  = 1'b1;
        exp_a[3].free  = 1'b1;
        exp_a[2].fire  = 4'b0001;
        exp_a[3].fire  = 4'b0010;
        exp_a[4].fire  = 4'b0101;
        exp_a[7].free  = 1'b1;
        exp_a[8].fire  = 4'b0001;
        exp_a[9].fire  = 4'b0010;
        exp_a[10].fire = 4'b0100;
        exp_a[11].fire = 4'b1000;
        exp_a[13].drv  = 1'b1;
        load_exp(16);
        for (int c = 0; c < 16; c++) begin
            check_obs({b1.o_free, b1.o_fire, b1.o_driveNext}, c, "reset_mid");
            b1.i_drive = (c == 0 || c == 2 || c == 6);
            rst        = (c == 4) ? 1'b0 : 1'b1;
            tick();
        end

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
